// File: rtl/fxp_requant_pipe_pkg.sv
// Shared fixed-point constants and rounding-mode encodings for the requantiser
// and the neighbouring multiplier/accumulator blocks.
package fxp_requant_pipe_pkg;

    localparam int ANCHO      = 16;
    localparam int RESOLUCION = 8;

    localparam int DEF_WIDTH = ANCHO;
    localparam int DEF_FRAC  = RESOLUCION;

    typedef enum logic [1:0] {
        RND_FLOOR     = 2'b00,
        RND_HALF_UP   = 2'b01,
        RND_HALF_EVEN = 2'b10,
        RND_ZERO      = 2'b11
    } rnd_mode_t;

endpackage

// File: rtl/fxp_requant_pipe_if.sv
// Sample-in / result-out bundle of the requantiser.
interface fxp_requant_pipe_if #(
    parameter int WIDTH = 16
);
    // Both sides: a word moves on a rising edge where valid & ready are high;
    // valid must not depend on ready, and payload is held while valid & !ready.
    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     in_data;
    logic [1:0]             in_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_sat;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

endinterface

// File: rtl/fxp_saturate.sv
// Signed range check and clip from IN_W bits down to OUT_W bits.
module fxp_saturate #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             sat
);

    // Value fits when every bit from the output sign bit upward matches.
    logic [IN_W-OUT_W:0] upper;
    logic                in_range;

    assign upper    = din[IN_W-1:OUT_W-1];
    assign in_range = (&upper) | (~|upper);
    assign sat      = ~in_range;

    always_comb begin
        dout = din[OUT_W-1:0];
        if (!in_range) begin
            dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fxp_requant_pipe.sv
// Two-stage requantiser: Q(2I).(2F) product to saturated Q(I).(F) with four
// rounding modes and saturation statistics.
module fxp_requant_pipe
    import fxp_requant_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    fxp_requant_pipe_if.slave    bus,
    output logic [CNT_W-1:0]     sat_count,
    output logic                 sat_sticky,
    input  logic                 stat_clr
);

    localparam int SW = 2*WIDTH + 1;
    localparam int RW = SW - FRAC;
    localparam logic [SW-1:0] HALF_LSB = SW'(1) << (FRAC-1);
    localparam logic [SW-1:0] FULL_LSB = SW'(1) << FRAC;

    logic             advance;
    logic [SW-1:0]    bias;
    logic [SW-1:0]    sum;
    logic [SW-1:0]    sum_q;
    logic             v1_q;
    logic [WIDTH-1:0] sat_data;
    logic             sat_flag;
    logic             xfer;
    logic             unused_frac;

    assign advance      = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = advance;
    assign xfer         = bus.out_valid & bus.out_ready;

    // Bias is chosen from the mode that travels with this sample.
    always_comb begin
        bias = '0;
        case (bus.in_mode)
            RND_FLOOR:     bias = '0;
            RND_HALF_UP:   bias = HALF_LSB;
            RND_HALF_EVEN: bias = HALF_LSB - SW'(1) + SW'(bus.in_data[FRAC]);
            RND_ZERO:      bias = bus.in_data[2*WIDTH-1] ? (FULL_LSB - SW'(1)) : '0;
            default:       bias = '0;
        endcase
    end

    // One guard bit keeps the biased sum from wrapping at the positive limit.
    assign sum = {bus.in_data[2*WIDTH-1], bus.in_data} + bias;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0;
            sum_q <= '0;
        end else if (advance) begin
            v1_q  <= bus.in_valid;
            sum_q <= sum;
        end
    end

    fxp_saturate #(
        .IN_W  (RW),
        .OUT_W (WIDTH)
    ) u_sat (
        .din  (sum_q[SW-1:FRAC]),
        .dout (sat_data),
        .sat  (sat_flag)
    );

    assign unused_frac = ^sum_q[FRAC-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
        end else if (advance) begin
            bus.out_valid <= v1_q;
            bus.out_data  <= sat_data;
            bus.out_sat   <= sat_flag;
        end
    end

    // Clear is applied before the event, so a coinciding clip counts as one.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count  <= '0;
            sat_sticky <= 1'b0;
        end else begin
            if (stat_clr) begin
                sat_count  <= '0;
                sat_sticky <= 1'b0;
            end
            if (xfer && bus.out_sat) begin
                sat_sticky <= 1'b1;
                if (stat_clr)
                    sat_count <= CNT_W'(1);
                else if (sat_count != {CNT_W{1'b1}})
                    sat_count <= sat_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/fxp_requant_pipe.md
Name: fxp_requant_pipe

Overview:
- Parametrised, pipelined successor to the fixed-point product truncator.
- Takes a signed 2W-bit product in Q(2I).(2F) format and requantises it to a signed W-bit Q(I).(F) result.
- Provides four run-time-selectable rounding modes, per-sample saturation flagging, a saturating overflow counter and a sticky overflow flag.
- Sits between the fixed-point multiplier and the accumulator/DAC path; valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, output word width W (signed, two's complement).
- FRAC, 8, output fractional bits F; input has 2F fractional bits; legal range 1..WIDTH-2.
- CNT_W, 8, width of the saturation event counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  2*WIDTH  signed product, 2F fractional bits.
- in_mode  in  2  rounding mode, sampled with in_data: 00 floor/truncate, 01 round half up, 10 round half even, 11 round toward zero.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  requantised, saturated result.
- out_sat  out  1  this result was clipped.
- sat_count  out  CNT_W  number of clipped results transferred; saturates at all-ones.
- sat_sticky  out  1  set on any transferred clipped result; held until cleared.
- stat_clr  in  1  clears sat_count and sat_sticky.

Behaviour:
- Reset: out_valid=0, out_data=0, out_sat=0, sat_count=0, sat_sticky=0, internal stage-1 valid=0. Reset mid-operation discards both stages.
- Pipeline control:
  - Two register stages; latency is 2 cycles from accepted input to out_valid when unstalled.
  - advance = ~out_valid | out_ready; in_ready = advance (combinational).
  - The whole pipeline holds when advance=0. Bubbles propagate; throughput is one sample per cycle.
  - out_data and out_sat are stable while out_valid=1 and out_ready=0.
- Stage 1 (rounding):
  - Sign-extend in_data to 2W+1 bits so the bias addition never wraps.
  - Add bias B by mode:
    - 00: B=0.
    - 01: B=2^(F-1).
    - 10: B=2^(F-1)-1+in_data[F].
    - 11: B=(2^F-1) if in_data negative, else 0.
  - Register the sum and valid.
- Stage 2 (shift and saturate):
  - r = sum >>> F (arithmetic shift), giving 2W+1-F significant bits.
  - If r[2W-F:W-1] are all equal, out_data = r[W-1:0] and out_sat=0.
  - Otherwise out_data = 0x7FF…F if r is positive, 0x800…0 if negative, and out_sat=1.
  - Discarded low F bits are dropped.
- Statistics, updated on transfer (out_valid & out_ready):
  - If out_sat, sat_count increments, holding at 2^CNT_W-1, and sat_sticky is set.
  - If stat_clr coincides with a counted transfer, the result is sat_count=1 and sat_sticky=1 (clear first, then event), so no event is lost.
  - stat_clr alone zeros both outputs next cycle.
- in_mode changes take effect per sample. Mode is carried with the data, never applied retroactively.

Decomposition:
- Shared constants header carries the rounding-mode encodings (RND_FLOOR, RND_HALF_UP, RND_HALF_EVEN, RND_ZERO) and the default WIDTH/FRAC, alongside the existing ancho/resolucion constants.
- One natural combinational sub-module: fxp_saturate (parameters IN_W, OUT_W) implementing the range check and clip of stage 2. It is reusable by the accumulator.
- Rounding bias logic stays inline.

Test Plan (WIDTH=16, FRAC=8; input LSB = 2^-16, output LSB = 2^-8):
- Exact value: in_data=0x0003_6000 (3.375), any mode, out_ready=1 -> out_data=0x0360 two cycles later, out_sat=0.
- Positive tie at 1.5 output LSB: in_data=0x0000_0180 -> mode 00:0x0001, 01:0x0002, 10:0x0002, 11:0x0001.
- Positive tie at 2.5 LSB: in_data=0x0000_0280 -> mode 01:0x0003, 10:0x0002.
- Negative tie at -1.5 LSB: in_data=0xFFFF_FE80 -> mode 00:0xFFFE, 01:0xFFFF, 10:0xFFFE, 11:0xFFFF.
- Saturation:
  - in_data=0x0100_0000 -> 0x7FFF, out_sat=1.
  - in_data=0x8000_0000 -> 0x8000, out_sat=1.
  - in_data=0x007F_FF80 in mode 01 -> rounds to 128.0 -> 0x7FFF, out_sat=1.
  - in_data=0x7FFF_FF80 in mode 01 -> no wrap, 0x7FFF.
  - sat_count=4 and sat_sticky=1 after these four.
- Backpressure and statistics:
  - out_ready=0 for 5 cycles with continuous in_valid -> in_ready=0 once out_valid=1; held out_data unchanged; no sample lost or duplicated, order preserved.
  - 300 saturating transfers -> sat_count=0xFF.
  - stat_clr together with a saturating transfer -> sat_count=1, sat_sticky=1.
  - Reset asserted mid-stream -> out_valid=0 next cycle and counters=0.
